// File: rtl/io_pkg.sv
// Shared definitions for the GPU load-link receiver.
// Holds the FSM state encoding, the token field layout and the default
// CNN / image region base addresses used by io_stream_receiver.
package io_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StExpand = 2'd2,
    StFinish = 2'd3
  } state_t;

  // Token layout: bit 15 is the bit value, bits 14:0 hold (run length - 1).
  localparam int unsigned TOKEN_VAL_BIT = 15;
  localparam int unsigned RUN_W         = 15;

  // Packed memory word width.
  localparam int unsigned WORD_W = 16;

  // Default first write addresses for each stream kind.
  localparam logic [15:0] CNN_BASE_DEF = 16'h0000;
  localparam logic [15:0] IMG_BASE_DEF = 16'h8000;

endpackage

// File: rtl/rle_unpacker.sv
// Run-length token expander.
// Holds the current token (bit value + remaining run), shifts one decoded bit
// per enabled clock into a 16-bit MSB-first shift register and flags the
// cycle in which the 16th bit of a word is being shifted.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-low reset
//   clear        drop any partially assembled word (start of a new stream)
//   load_token   capture token as the current run
//   token        token word: [15] bit value, [14:0] run-1
//   shift_en     shift one bit of the current run this cycle
//   word_valid   this shift completes a 16-bit word (combinational strobe)
//   word         completed word, valid with word_valid
//   run_last     the current shift uses the final bit of the run
module rle_unpacker
  import io_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_token,
  input  logic [15:0]       token,
  input  logic              shift_en,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic              run_last
);

  logic             bit_val_q;
  logic [RUN_W-1:0] run_q;
  logic [14:0]      shift_q;
  logic [3:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_val_q <= 1'b0;
      run_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
    end else begin
      if (clear) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (shift_en) begin
        // Only the low 15 bits are kept: the 16th bit goes straight into word.
        shift_q <= {shift_q[13:0], bit_val_q};
        cnt_q   <= cnt_q + 4'd1;
        if (run_q != '0) begin
          run_q <= run_q - RUN_W'(1);
        end
      end
      if (load_token) begin
        bit_val_q <= token[TOKEN_VAL_BIT];
        run_q     <= token[RUN_W-1:0];
      end
    end
  end

  always_comb begin
    word       = {shift_q, bit_val_q};
    word_valid = shift_en && (cnt_q == 4'd15);
    run_last   = (run_q == '0);
  end

endmodule

// File: rtl/io_stream_receiver.sv
// Accelerator-side end of the GPU load link.
// Accepts interrupt-framed 16-bit words (header N, then RLE tokens), expands
// them into packed 16-bit words and writes them to the CNN or image region.
// A load=0 interrupt in IDLE produces a one-cycle process_start pulse.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-low reset
//   interrupt      command strobe, qualified by load / cnn
//   load           1 = stream transfer, 0 = process command
//   cnn            1 = CNN stream, 0 = image stream
//   data           header / token word from the GPU
//   done           current word consumed, present the next one
//   mem_we         memory write strobe
//   mem_addr       memory write address
//   mem_wdata      memory write data
//   stream_done    one-cycle pulse when a stream completes
//   cnn_loaded     sticky: a CNN stream completed
//   img_loaded     sticky: an image stream completed
//   process_start  one-cycle pulse on a process command
//   busy           high outside IDLE
module io_stream_receiver
  import io_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] CNN_BASE = ADDR_W'(CNN_BASE_DEF),
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(IMG_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              load,
  input  logic              cnn,
  input  logic [15:0]       data,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              stream_done,
  output logic              cnn_loaded,
  output logic              img_loaded,
  output logic              process_start,
  output logic              busy
);

  state_t state_q, state_d;

  logic              cnn_q;
  logic [15:0]       n_q;
  logic [15:0]       written_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              cnn_loaded_q;
  logic              img_loaded_q;
  logic              process_start_q;

  logic              start_stream;
  logic              start_process;
  logic              last_word;
  logic              load_token;
  logic              shift_en;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              run_last;

  // Commands are only decoded in IDLE; interrupts elsewhere are dropped.
  assign start_stream  = (state_q == StIdle) && interrupt && load;
  assign start_process = (state_q == StIdle) && interrupt && !load;
  // The word being completed now is the final one of the stream.
  assign last_word     = ((written_q + 16'd1) == n_q);

  rle_unpacker u_rle_unpacker (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_stream),
    .load_token (load_token),
    .token      (data),
    .shift_en   (shift_en),
    .word_valid (word_valid),
    .word       (word),
    .run_last   (run_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Completing the last word wins over an exhausted run,
  // so any remaining run bits are discarded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_stream) begin
          state_d = (data == 16'd0) ? StFinish : StReq;
        end
      end
      StReq: state_d = StExpand;
      StExpand: begin
        if (word_valid && last_word) begin
          state_d = StFinish;
        end else if (run_last) begin
          state_d = StReq;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    done        = 1'b0;
    stream_done = 1'b0;
    load_token  = 1'b0;
    shift_en    = 1'b0;
    busy        = (state_q != StIdle);
    unique case (state_q)
      StReq: begin
        done       = 1'b1;
        load_token = 1'b1;
      end
      StExpand: shift_en = 1'b1;
      StFinish: begin
        done        = 1'b1;
        stream_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Header, address and write datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnn_q           <= 1'b0;
      n_q             <= '0;
      written_q       <= '0;
      addr_q          <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cnn_loaded_q    <= 1'b0;
      img_loaded_q    <= 1'b0;
      process_start_q <= 1'b0;
    end else begin
      mem_we_q        <= word_valid;
      process_start_q <= start_process;
      if (start_stream) begin
        cnn_q     <= cnn;
        n_q       <= data;
        written_q <= '0;
        addr_q    <= cnn ? CNN_BASE : IMG_BASE;
      end else if (word_valid) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word;
        addr_q      <= addr_q + ADDR_W'(1);
        written_q   <= written_q + 16'd1;
      end
      if (state_q == StFinish) begin
        if (cnn_q) begin
          cnn_loaded_q <= 1'b1;
        end else begin
          img_loaded_q <= 1'b1;
        end
      end
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cnn_loaded    = cnn_loaded_q;
  assign img_loaded    = img_loaded_q;
  assign process_start = process_start_q;

endmodule

// File: tb/tb_io_stream_receiver.sv
// Directed bench for io_stream_receiver. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_io_stream_receiver;

  logic        clk;
  logic        rst;
  logic        interrupt;
  logic        load;
  logic        cnn;
  logic [15:0] data;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stream_done;
  logic        cnn_loaded;
  logic        img_loaded;
  logic        process_start;
  logic        busy;

  int total;
  int bad;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          n_done;
  int          n_sdone;
  int          n_exp;
  bit          timed_out;

  io_stream_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .interrupt     (interrupt),
    .load          (load),
    .cnn           (cnn),
    .data          (data),
    .done          (done),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .stream_done   (stream_done),
    .cnn_loaded    (cnn_loaded),
    .img_loaded    (img_loaded),
    .process_start (process_start),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPU model: issues the header with an interrupt, then answers each done
  // pulse with the next token. Optionally pulses a stray interrupt or applies
  // reset at loop cycle pulse_at / abort_at. Records writes and pulse counts.
  task automatic run_stream(input logic c, input logic [15:0] n, input logic [15:0] t0,
                            input logic [15:0] t1, input logic [15:0] t2, input int ntok,
                            input int pulse_at, input int abort_at);
    logic [15:0] toks[3];
    int ti;
    bit fin;
    toks[0] = t0;
    toks[1] = t1;
    toks[2] = t2;
    ti = 0;
    fin = 1'b0;
    wa.delete();
    wd.delete();
    n_done = 0;
    n_sdone = 0;
    n_exp = 0;
    timed_out = 1'b0;
    @(negedge clk);
    interrupt = 1'b1;
    load = 1'b1;
    cnn = c;
    data = n;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      interrupt = 1'b0;
      load = 1'b0;
      cnn = 1'b0;
      if (k == pulse_at) begin
        interrupt = 1'b1;
        load = 1'b1;
        cnn = ~c;
      end
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
      if (busy && !done) n_exp++;
      if (done) begin
        n_done++;
        if (ti < ntok) begin
          data = toks[ti];
          ti++;
        end else begin
          data = 16'h0000;
        end
      end
      if (stream_done) begin
        n_sdone++;
        fin = 1'b1;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        fin = 1'b1;
      end
    end
    if (!fin) timed_out = 1'b1;
    interrupt = 1'b0;
    load = 1'b0;
    @(negedge clk);
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    rst = 1'b0;
    interrupt = 1'b0;
    load = 1'b0;
    cnn = 1'b0;
    data = 16'h0000;
    repeat (3) @(negedge clk);
    obs = {done, mem_we, mem_addr, mem_wdata, stream_done, cnn_loaded, img_loaded,
           process_start, busy};
    total++;
    if (obs !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cnn_stream();
    logic [15:0] ea[2];
    logic [15:0] ed[2];
    ea[0] = 16'h0000; ed[0] = 16'hFFFF;
    ea[1] = 16'h0001; ed[1] = 16'h00FF;
    run_stream(1'b1, 16'd2, 16'h800F, 16'h0007, 16'h8007, 3, -1, -1);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL cnn_timeout got=1 want=0"); end
    total++;
    if (wa.size() !== 2) begin bad++; $display("FAIL cnn_nwrites got=%0d want=2", wa.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        bad++;
        $display("FAIL cnn_write%0d got=%h:%h want=%h:%h", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 16'hxxxx,
                 ea[i], ed[i]);
      end
    end
    total++;
    if (n_done !== 4) begin bad++; $display("FAIL cnn_done_pulses got=%0d want=4", n_done); end
    total++;
    if (n_sdone !== 1) begin bad++; $display("FAIL cnn_stream_done got=%0d want=1", n_sdone); end
    total++;
    if ({cnn_loaded, img_loaded} !== 2'b10) begin
      bad++;
      $display("FAIL cnn_flags got=%b want=10", {cnn_loaded, img_loaded});
    end
  endtask

  task automatic test_img_stream();
    run_stream(1'b0, 16'd3, 16'h802F, 16'h0000, 16'h0000, 1, -1, -1);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL img_timeout got=1 want=0"); end
    total++;
    if (wa.size() !== 3) begin bad++; $display("FAIL img_nwrites got=%0d want=3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= wa.size() || wa[i] !== 16'h8000 + 16'(i) || wd[i] !== 16'hFFFF) begin
        bad++;
        $display("FAIL img_write%0d got=%h:%h want=%h:ffff", i,
                 (i < wa.size()) ? wa[i] : 16'hxxxx, (i < wd.size()) ? wd[i] : 16'hxxxx,
                 16'h8000 + 16'(i));
      end
    end
    total++;
    if (n_done !== 2) begin bad++; $display("FAIL img_done_pulses got=%0d want=2", n_done); end
    total++;
    if (n_exp !== 48) begin bad++; $display("FAIL img_expand_cycles got=%0d want=48", n_exp); end
    total++;
    if ({cnn_loaded, img_loaded} !== 2'b11) begin
      bad++;
      $display("FAIL img_flags got=%b want=11", {cnn_loaded, img_loaded});
    end
  endtask

  task automatic test_truncate();
    run_stream(1'b0, 16'd1, 16'h801F, 16'h0000, 16'h0000, 1, -1, -1);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL trunc_timeout got=1 want=0"); end
    total++;
    if (wa.size() !== 1 || wa[0] !== 16'h8000 || wd[0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL trunc_write got_n=%0d want=1 write 8000:ffff", wa.size());
    end
    total++;
    if (n_exp !== 16) begin bad++; $display("FAIL trunc_expand_cycles got=%0d want=16", n_exp); end
    total++;
    if (n_done !== 2) begin bad++; $display("FAIL trunc_done_pulses got=%0d want=2", n_done); end
  endtask

  task automatic test_zero_and_process();
    run_stream(1'b1, 16'd0, 16'h0000, 16'h0000, 16'h0000, 0, -1, -1);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout got=1 want=0"); end
    total++;
    if (wa.size() !== 0) begin bad++; $display("FAIL zero_nwrites got=%0d want=0", wa.size()); end
    total++;
    if (n_done !== 1 || n_sdone !== 1) begin
      bad++;
      $display("FAIL zero_pulses got done=%0d sdone=%0d want 1 1", n_done, n_sdone);
    end
    interrupt = 1'b1;
    load = 1'b0;
    @(negedge clk);
    interrupt = 1'b0;
    total++;
    if ({process_start, busy} !== 2'b10) begin
      bad++;
      $display("FAIL process_pulse got=%b want=10", {process_start, busy});
    end
    @(negedge clk);
    total++;
    if ({process_start, busy} !== 2'b00) begin
      bad++;
      $display("FAIL process_one_cycle got=%b want=00", {process_start, busy});
    end
  endtask

  task automatic test_interrupt_ignored();
    run_stream(1'b1, 16'd2, 16'h800F, 16'h0007, 16'h8007, 3, 5, -1);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL irq_timeout got=1 want=0"); end
    total++;
    if (wa.size() !== 2 || wa[0] !== 16'h0000 || wd[0] !== 16'hFFFF ||
        wa[1] !== 16'h0001 || wd[1] !== 16'h00FF) begin
      bad++;
      $display("FAIL irq_writes got_n=%0d want 0000:ffff 0001:00ff", wa.size());
    end
    total++;
    if (n_done !== 4) begin bad++; $display("FAIL irq_done_pulses got=%0d want=4", n_done); end
  endtask

  task automatic test_abort();
    logic [38:0] obs;
    run_stream(1'b1, 16'd2, 16'h800F, 16'h0007, 16'h8007, 3, -1, 9);
    obs = {done, mem_we, mem_addr, mem_wdata, stream_done, cnn_loaded, img_loaded,
           process_start, busy};
    total++;
    if (obs !== 39'd0) begin bad++; $display("FAIL abort_outputs got=%h want=0", obs); end
    total++;
    if (wa.size() !== 0) begin bad++; $display("FAIL abort_nwrites got=%0d want=0", wa.size()); end
    rst = 1'b1;
    @(negedge clk);
    run_stream(1'b1, 16'd1, 16'h800F, 16'h0000, 16'h0000, 1, -1, -1);
    total++;
    if (wa.size() !== 1 || wa[0] !== 16'h0000 || wd[0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL abort_restart got_n=%0d want=1 write 0000:ffff", wa.size());
    end
    total++;
    if ({cnn_loaded, img_loaded} !== 2'b10) begin
      bad++;
      $display("FAIL abort_flags got=%b want=10", {cnn_loaded, img_loaded});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_cnn_stream();
    test_img_stream();
    test_truncate();
    test_zero_and_process();
    test_interrupt_ignored();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
